cart_rom_fetch: RTL and testbench
=================================

Name: cart_rom_fetch

Overview:
- Sits directly downstream of the MBC mapper. Takes the mapped 23-bit cartridge ROM byte address and the CPU read strobe, and returns the ROM byte.
- Fetches 16-bit words from the SDRAM controller through a single-word line buffer with one tag.
- Stalls the CPU with `cart_wait` while a miss is outstanding.
- Invalidates the buffer on cartridge download and on savestate load.

Parameters:
- `ADDR_W`, 23, byte-address width of `mbc_addr` (word address is `ADDR_W-1` bits).
- `TIMEOUT`, 255, maximum cycles `sdram_req` is held without `sdram_ack` before the fetch is abandoned.

Ports:
- `clk_sys`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `ce_cpu`  in  1  CPU clock enable; `cart_rd` is sampled only when high.
- `cart_rd`  in  1  CPU cartridge ROM read strobe (A15=0 region).
- `mbc_addr`  in  23  mapped ROM byte address from the mapper.
- `invalidate`  in  1  one-cycle pulse (cart download start/end, `savestate_load`); clears the buffer.
- `cart_do`  out  8  ROM byte for `mbc_addr`.
- `cart_wait`  out  1  CPU stall; high while a read miss is unresolved.
- `sdram_req`  out  1  level request to the SDRAM controller.
- `sdram_addr`  out  22  word address, equal to `mbc_addr[22:1]` latched at miss.
- `sdram_ack`  in  1  one-cycle pulse; `sdram_rdata` is valid in the same cycle.
- `sdram_rdata`  in  16  fetched word; low byte = even address.
- `fetch_err`  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async, `reset_n`=0):
  - state=IDLE, `valid`=0, `tag`=0, `buf`=16'hFFFF.
  - `sdram_req`=0, `sdram_addr`=0, `cart_wait`=0, `fetch_err`=0, timeout counter=0.
  - `cart_do`=8'hFF.
- Hit:
  - Condition: `valid` && `tag`==`mbc_addr[22:1]`.
  - `cart_do` = `mbc_addr[0]` ? `buf[15:8]` : `buf[7:0]`, combinational, zero-cycle latency.
  - `cart_wait`=0.
- Miss:
  - Condition: `cart_rd` && `ce_cpu` && !hit in IDLE.
  - `cart_wait` rises combinationally in the same cycle and stays high until the hit is resolved.
  - `cart_do`=8'hFF while waiting.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE → FETCH on a miss. Latch `sdram_addr`=`mbc_addr[22:1]`, set `sdram_req`=1 at the next edge, clear the counter.
  - FETCH: `sdram_req` stays high; `sdram_addr` is stable; the counter increments each cycle.
    - On `sdram_ack`: `buf`<=`sdram_rdata`, `tag`<=`sdram_addr`, `valid`<=1 (unless killed), `sdram_req`<=0, → HOLD.
    - On counter==`TIMEOUT` with no ack: `sdram_req`<=0, `fetch_err`<=1, `buf`<=16'hFFFF, `tag`<=`sdram_addr`, `valid`<=1, → HOLD. The CPU reads FF instead of hanging.
  - HOLD: one cycle, → IDLE, where the hit path resolves. This guarantees `sdram_req` is low for at least 1 cycle between requests.
- Latency: miss detected at cycle N, `sdram_req` high at N+1, ack at N+1+k, `cart_wait` low at N+3+k (after HOLD, the hit in IDLE).
- `mbc_addr` changes during FETCH (bank switch): the fetch completes unaltered. On return to IDLE the tag is compared against the current `mbc_addr`; a mismatch causes a new miss.
- `cart_rd` drops during FETCH: the fetch still completes and fills the buffer; `cart_wait` drops to 0 immediately.
- `invalidate` in IDLE/HOLD: `valid`<=0 next edge.
- `invalidate` during FETCH:
  - Sets a `kill` flag. The ack still completes the handshake, but `valid` stays 0, `kill` clears, and the following IDLE re-misses.
  - `invalidate` coincident with `sdram_ack`: treated as killed.
- Never issue a new `sdram_req` while one is outstanding. `sdram_ack` outside FETCH is ignored.
- Word boundary: bytes 2n and 2n+1 share one fetch; odd→even crossing (e.g. 0x3FFF→0x4000) is a new tag and a miss.

Test Plan:
- Reset, read `mbc_addr`=0x000100, ack after 3 cycles with `rdata`=0x31C3 → `cart_wait` high 6 cycles, `cart_do`=0xC3. Then read 0x000101 → `cart_do`=0x31 with zero wait and no `sdram_req`.
- Read 0x003FFF, then 0x004000 → two fetches with `sdram_addr` 0x001FFF then 0x002000; returned bytes are correct high/low halves.
- Miss on 0x010000; `invalidate` pulsed mid-FETCH; ack `rdata`=0xAA55 → after HOLD a second `sdram_req` is issued for 0x008000. `cart_do` stays 0xFF with `cart_wait` high until the second ack.
- Miss on 0x020000, change `mbc_addr` to 0x024000 before ack → first fetch completes, a second fetch is issued for word 0x012000, and `cart_do` comes from the second word.
- Never ack → `sdram_req` drops after `TIMEOUT`+1 cycles, `fetch_err`=1, `cart_do`=0xFF, `cart_wait` drops. Reset clears `fetch_err`.
- Assert `reset_n`=0 mid-FETCH (asynchronously, between edges) → `sdram_req` and `cart_wait` go low immediately, `valid`=0, state=IDLE.

Source files
------------

// File: rtl/cart_rom_fetch.sv
// -----------------------------------------------------------------------------
// cart_rom_fetch
//
// Cartridge ROM byte fetch path between the MBC mapper and the SDRAM
// controller. A single 16-bit line buffer with one word tag serves CPU reads
// combinationally on a hit. A miss stalls the CPU via cart_wait while one
// word is fetched from SDRAM. A fetch that is never acknowledged is abandoned
// after TIMEOUT cycles. In that case the line is filled with 16'hFFFF and a
// sticky error is flagged, so the CPU reads FF instead of hanging.
//
// Ports:
//   clk_sys      system clock, all state changes on the rising edge
//   reset_n      asynchronous active-low reset
//   ce_cpu       CPU clock enable; qualifies cart_rd for miss detection
//   cart_rd      CPU cartridge ROM read strobe
//   mbc_addr     mapped ROM byte address
//   invalidate   one-cycle pulse that clears the line buffer
//   cart_do      ROM byte for mbc_addr (8'hFF when not available)
//   cart_wait    CPU stall while a read miss is unresolved
//   sdram_req    level request to the SDRAM controller
//   sdram_addr   word address of the outstanding fetch
//   sdram_ack    one-cycle acknowledge, sdram_rdata valid with it
//   sdram_rdata  fetched word, low byte = even byte address
//   fetch_err    sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module cart_rom_fetch #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_cpu,
  input  logic              cart_rd,
  input  logic [ADDR_W-1:0] mbc_addr,
  input  logic              invalidate,
  output logic [7:0]        cart_do,
  output logic              cart_wait,
  output logic              sdram_req,
  output logic [ADDR_W-2:0] sdram_addr,
  input  logic              sdram_ack,
  input  logic [15:0]       sdram_rdata,
  output logic              fetch_err
);

  localparam int                CNT_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t state, state_next;

  logic              valid;
  logic              kill;
  logic [ADDR_W-2:0] tag;
  logic [15:0]       line_buf;
  logic [CNT_W-1:0]  wait_cnt;

  logic hit;
  logic miss;
  logic fill_ok;
  logic fill_timeout;

  assign hit = valid && (tag == mbc_addr[ADDR_W-1:1]);

  // The byte is only presented once the stall has cleared, so the CPU never
  // sees stale data from a previous line while it is still waiting.
  assign cart_do = (hit && !cart_wait)
                 ? (mbc_addr[0] ? line_buf[15:8] : line_buf[7:0])
                 : 8'hFF;

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_next   = state;
    miss         = 1'b0;
    fill_ok      = 1'b0;
    fill_timeout = 1'b0;
    cart_wait    = 1'b0;
    case (state)
      IDLE: begin
        // reset_n gates the stall so it drops the instant reset asserts,
        // even if the CPU is still holding cart_rd.
        miss      = reset_n && cart_rd && ce_cpu && !hit;
        cart_wait = miss;
        if (miss) state_next = FETCH;
      end
      FETCH: begin
        cart_wait = cart_rd;
        if (sdram_ack) begin
          fill_ok    = 1'b1;
          state_next = HOLD;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          fill_timeout = 1'b1;
          state_next   = HOLD;
        end
      end
      HOLD: begin
        // The stall is held through HOLD; the hit resolves back in IDLE.
        // This cycle also guarantees a low gap on sdram_req between requests.
        cart_wait  = cart_rd;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: line_buf is a plain register rather than a memory, so it takes a
  // reset value like any other flop.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid      <= 1'b0;
      kill       <= 1'b0;
      tag        <= '0;
      line_buf   <= 16'hFFFF;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      fetch_err  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (invalidate) valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss) begin
            sdram_addr <= mbc_addr[ADDR_W-1:1];
            sdram_req  <= 1'b1;
            wait_cnt   <= '0;
            kill       <= 1'b0;
          end
        end
        FETCH: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (invalidate) kill <= 1'b1;
          if (fill_ok || fill_timeout) begin
            // The handshake always completes. A kill raised earlier in this
            // fetch, or on the ack cycle itself, leaves the line invalid so
            // the next IDLE cycle re-misses.
            sdram_req <= 1'b0;
            tag       <= sdram_addr;
            line_buf  <= fill_ok ? sdram_rdata : 16'hFFFF;
            valid     <= !(kill || invalidate);
            kill      <= 1'b0;
            if (fill_timeout) fetch_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_rom_fetch.sv
// -----------------------------------------------------------------------------
// tb_cart_rom_fetch
//
// Self-checking bench for cart_rom_fetch. An SDRAM responder acknowledges
// requests a programmable number of cycles after sdram_req rises. It pops the
// expected word address of each fetch from a scoreboard queue. CPU reads push
// their expected byte when driven and pop it when cart_wait clears.
// -----------------------------------------------------------------------------
module tb_cart_rom_fetch;

  localparam int ADDR_W  = 23;
  localparam int TIMEOUT = 255;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce_cpu;
  logic        cart_rd;
  logic [22:0] mbc_addr;
  logic        invalidate;
  logic [7:0]  cart_do;
  logic        cart_wait;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic [15:0] sdram_rdata;
  logic        fetch_err;

  cart_rom_fetch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ce_cpu     (ce_cpu),
    .cart_rd    (cart_rd),
    .mbc_addr   (mbc_addr),
    .invalidate (invalidate),
    .cart_do    (cart_do),
    .cart_wait  (cart_wait),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_rdata(sdram_rdata),
    .fetch_err  (fetch_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  logic [21:0] fetch_q[$];
  logic [7:0]  rd_q[$];
  logic [15:0] mem [logic [21:0]];

  bit ack_en       = 1'b1;
  int ack_lat      = 3;
  int req_cnt      = 0;
  int last_req_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [21:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[7:0] ^ 8'h5A, a[15:8] ^ {2'b00, a[21:16]} ^ 8'hC3};
  endfunction

  function automatic logic [7:0] byte_of(input logic [22:0] a);
    logic [15:0] w;
    w = word_of(a[22:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // SDRAM responder: ack in the (ack_lat+1)-th cycle that sdram_req is high.
  initial begin
    logic [21:0] exp_addr;
    sdram_ack   = 1'b0;
    sdram_rdata = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      sdram_ack = 1'b0;
      if (sdram_req) begin
        req_cnt++;
        if (ack_en && req_cnt == ack_lat + 1) begin
          sdram_ack   = 1'b1;
          sdram_rdata = word_of(sdram_addr);
          if (fetch_q.size() != 0) exp_addr = fetch_q.pop_front();
          else                     exp_addr = ~sdram_addr;
          check("fetch_addr", 32'(sdram_addr), 32'(exp_addr));
        end
      end else begin
        if (req_cnt != 0) last_req_len = req_cnt;
        req_cnt = 0;
      end
    end
  end

  // Called at drive time (just after a rising edge).
  task automatic read_byte(input logic [22:0] a, input logic [7:0] exp, input int exp_wait);
    int waited = 0;
    int bad_do = 0;
    bit done   = 1'b0;
    mbc_addr = a;
    cart_rd  = 1'b1;
    rd_q.push_back(exp);
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk_sys);
      if (cart_wait) begin
        waited++;
        if (cart_do !== 8'hFF) bad_do++;
      end else begin
        done = 1'b1;
      end
    end
    check("read_done", 32'(done), 32'd1);
    check("cart_do", 32'(cart_do), 32'(rd_q.pop_front()));
    check("do_ff_while_wait", 32'(bad_do), 32'd0);
    check("wait_cycles", 32'(waited), 32'(exp_wait));
    if (exp_wait == 0) check("no_req_on_hit", 32'(sdram_req), 32'd0);
    @(posedge clk_sys);
    #1;
    cart_rd = 1'b0;
  endtask

  // Waits for a fetch to start, then invalidates (action 0) or bank-switches.
  task automatic after_req(input int action);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_sys);
      seen = sdram_req;
    end
    check("req_seen", 32'(seen), 32'd1);
    @(posedge clk_sys);
    #1;
    if (action == 0) invalidate = 1'b1;
    else             mbc_addr   = 23'h024000;
    @(posedge clk_sys);
    #1;
    invalidate = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset_n    = 1'b0;
    ce_cpu     = 1'b1;
    cart_rd    = 1'b0;
    invalidate = 1'b0;
    mbc_addr   = '0;
    mem[22'h000080] = 16'h31C3;
    mem[22'h008000] = 16'hAA55;

    // Reset state
    #12;
    check("rst_cart_do", 32'(cart_do), 32'hFF);
    check("rst_cart_wait", 32'(cart_wait), 32'd0);
    check("rst_sdram_req", 32'(sdram_req), 32'd0);
    check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    // Basic miss then same-word hit
    fetch_q.push_back(22'h000080);
    read_byte(23'h000100, byte_of(23'h000100), 6);
    read_byte(23'h000101, byte_of(23'h000101), 0);

    // Odd -> even word crossing
    fetch_q.push_back(22'h001FFF);
    fetch_q.push_back(22'h002000);
    read_byte(23'h003FFF, byte_of(23'h003FFF), 6);
    read_byte(23'h004000, byte_of(23'h004000), 6);

    // Invalidate mid-FETCH forces a second fetch of the same word
    fetch_q.push_back(22'h008000);
    fetch_q.push_back(22'h008000);
    fork
      read_byte(23'h010000, byte_of(23'h010000), 12);
      after_req(0);
    join

    // Bank switch mid-FETCH: second fetch for the new word supplies the byte
    fetch_q.push_back(22'h010000);
    fetch_q.push_back(22'h012000);
    fork
      read_byte(23'h020000, byte_of(23'h024000), 12);
      after_req(1);
    join

    // Timeout: never ack
    ack_en       = 1'b0;
    last_req_len = 0;
    read_byte(23'h030000, 8'hFF, TIMEOUT + 3);
    check("timeout_req_len", 32'(last_req_len), 32'(TIMEOUT + 1));
    check("timeout_fetch_err", 32'(fetch_err), 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_clears_err", 32'(fetch_err), 32'd0);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    ack_en  = 1'b1;
    @(posedge clk_sys);
    #1;

    // Asynchronous reset in the middle of a fetch
    fetch_q.push_back(22'h020000);
    read_byte(23'h040000, byte_of(23'h040000), 6);
    ack_en   = 1'b0;
    mbc_addr = 23'h040002;
    cart_rd  = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_sys);
      seen = sdram_req;
    end
    check("rst_fetch_started", 32'(seen), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_sdram_req", 32'(sdram_req), 32'd0);
    check("midrst_cart_wait", 32'(cart_wait), 32'd0);
    check("midrst_cart_do", 32'(cart_do), 32'hFF);
    @(posedge clk_sys);
    #1;
    cart_rd = 1'b0;
    reset_n = 1'b1;
    ack_en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      check("idle_after_rst", 32'(sdram_req), 32'd0);
    end
    @(posedge clk_sys);
    #1;
    // The previously filled word must miss again: reset cleared valid.
    fetch_q.push_back(22'h020000);
    read_byte(23'h040000, byte_of(23'h040000), 6);

    repeat (2) @(posedge clk_sys);
    check("fetch_q_empty", 32'(fetch_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
